// File: rtl/idu_decode_stage_pkg.sv
// idu_decode_stage_pkg: opcode/funct encodings, one-hot info bit indices and decode helpers
package idu_decode_stage_pkg;
  localparam int OP_INFO_WIDTH     = 11;
  localparam int ALU_INFO_WIDTH    = 10;
  localparam int BRANCH_INFO_WIDTH = 6;
  localparam int OP_ALU_IMM   = 0;
  localparam int OP_ALU_IMM_W = 1;
  localparam int OP_ALU       = 2;
  localparam int OP_ALU_W     = 3;
  localparam int OP_BRANCH    = 4;
  localparam int OP_JAL       = 5;
  localparam int OP_JALR      = 6;
  localparam int OP_LUI       = 7;
  localparam int OP_AUIPC     = 8;
  localparam int OP_LOAD      = 9;
  localparam int OP_STORE     = 10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;
  localparam int BRANCH_BEQ  = 0;
  localparam int BRANCH_BNE  = 1;
  localparam int BRANCH_BLT  = 2;
  localparam int BRANCH_BGE  = 3;
  localparam int BRANCH_BLTU = 4;
  localparam int BRANCH_BGEU = 5;
  localparam logic [6:0] OPC_ALU_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_ALU_IMM_W = 7'b0011011;
  localparam logic [6:0] OPC_ALU       = 7'b0110011;
  localparam logic [6:0] OPC_ALU_W     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_fmt_e;
  typedef struct packed {
    logic [OP_INFO_WIDTH-1:0]     op;
    logic [ALU_INFO_WIDTH-1:0]    alu;
    logic [BRANCH_INFO_WIDTH-1:0] br;
    logic [4:0]                   rs1;
    logic [4:0]                   rs2;
    logic [4:0]                   rd;
    logic                         rd_wen;
    logic                         illegal;
  } dec_t;
  // funct7 must be zero, except bit 5 which is allowed when alt (SUB/SRA) is legal
  function automatic logic f7_bad(input logic [6:0] f7, input logic alt);
    return |(f7 & {1'b1, ~alt, 5'h1F});
  endfunction
  function automatic logic [ALU_INFO_WIDTH-1:0] alu_onehot(input logic [2:0] f3, input logic sub, input logic sra);
    logic [ALU_INFO_WIDTH-1:0] r;
    r = '0;
    case (f3)
      3'b000: r[sub ? ALU_SUB : ALU_ADD] = 1'b1;
      3'b001: r[ALU_SLL] = 1'b1;
      3'b010: r[ALU_SLT] = 1'b1;
      3'b011: r[ALU_SLTU] = 1'b1;
      3'b100: r[ALU_XOR] = 1'b1;
      3'b101: r[sra ? ALU_SRA : ALU_SRL] = 1'b1;
      3'b110: r[ALU_OR] = 1'b1;
      default: r[ALU_AND] = 1'b1;
    endcase
    return r;
  endfunction
  function automatic logic [BRANCH_INFO_WIDTH-1:0] br_onehot(input logic [2:0] f3);
    logic [BRANCH_INFO_WIDTH-1:0] r;
    r = '0;
    case (f3)
      3'b000: r[BRANCH_BEQ] = 1'b1;
      3'b001: r[BRANCH_BNE] = 1'b1;
      3'b100: r[BRANCH_BLT] = 1'b1;
      3'b101: r[BRANCH_BGE] = 1'b1;
      3'b110: r[BRANCH_BLTU] = 1'b1;
      3'b111: r[BRANCH_BGEU] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/idu_decode_stage_imm_gen.sv
// idu_imm_gen: builds the sign-extended immediate (inst_i, fmt_i -> imm_o) for each instruction format
module idu_imm_gen
  import idu_decode_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;
  always_comb begin
    imm32 = fmt_i == IMM_I  ? {{20{inst_i[31]}}, inst_i[31:20]} :
            fmt_i == IMM_S  ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
            fmt_i == IMM_B  ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
            fmt_i == IMM_U  ? {inst_i[31:12], 12'b0} :
            fmt_i == IMM_J  ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
            fmt_i == IMM_SH ? {26'b0, inst_i[25:20]} : 32'b0;
    imm_o = {{(XLEN-32){imm32[31]}}, imm32};
  end
endmodule

// File: rtl/idu_decode_stage.sv
// idu_decode_stage: RV64I decode into one registered valid/ready slot (in: inst_i/pc_i handshake, flush_i; out: one-hot infos, regs, imm)
module idu_decode_stage
  import idu_decode_stage_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int PC_WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  inst_i,
  input  logic [PC_WIDTH-1:0]          pc_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [OP_INFO_WIDTH-1:0]     opcode_info_o,
  output logic [ALU_INFO_WIDTH-1:0]    alu_info_o,
  output logic [BRANCH_INFO_WIDTH-1:0] branch_info_o,
  output logic [XLEN-1:0]              imm_o,
  output logic [4:0]                   rs1_idx_o,
  output logic [4:0]                   rs2_idx_o,
  output logic [4:0]                   rd_idx_o,
  output logic                         rd_wen_o,
  output logic                         illegal_o
);
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            shift, bad, wr, is_alu;
  imm_fmt_e        fmt;
  dec_t            d, slot;
  logic [XLEN-1:0] imm, imm_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic            valid, accept;
  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign shift = f3[1:0] == 2'b01;
  always_comb begin
    d   = '0;
    fmt = IMM_NONE;
    bad = 1'b0;
    wr  = 1'b0;
    case (opc)
      OPC_ALU_IMM: begin
        d.op[OP_ALU_IMM] = 1'b1;
        wr  = 1'b1;
        fmt = shift ? IMM_SH : IMM_I;
        bad = shift & f7_bad({inst_i[31:26], 1'b0}, f3[2]);
      end
      OPC_ALU_IMM_W: begin
        d.op[OP_ALU_IMM_W] = 1'b1;
        wr  = 1'b1;
        fmt = shift ? IMM_SH : IMM_I;
        bad = shift ? f7_bad(f7, f3[2]) : f3 != 3'b000;
      end
      OPC_ALU: begin
        d.op[OP_ALU] = 1'b1;
        wr  = 1'b1;
        bad = f7_bad(f7, f3 == 3'b000 || f3 == 3'b101);
      end
      OPC_ALU_W: begin
        d.op[OP_ALU_W] = 1'b1;
        wr  = 1'b1;
        bad = (f3 != 3'b000 && !shift) || f7_bad(f7, f3 == 3'b000 || f3 == 3'b101);
      end
      OPC_BRANCH: begin
        d.op[OP_BRANCH] = 1'b1;
        fmt = IMM_B;
        bad = f3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        d.op[OP_JAL] = 1'b1;
        wr  = 1'b1;
        fmt = IMM_J;
      end
      OPC_JALR: begin
        d.op[OP_JALR] = 1'b1;
        wr  = 1'b1;
        fmt = IMM_I;
        bad = f3 != 3'b000;
      end
      OPC_LUI: begin
        d.op[OP_LUI] = 1'b1;
        wr  = 1'b1;
        fmt = IMM_U;
      end
      OPC_AUIPC: begin
        d.op[OP_AUIPC] = 1'b1;
        wr  = 1'b1;
        fmt = IMM_U;
      end
      OPC_LOAD: begin
        d.op[OP_LOAD] = 1'b1;
        wr  = 1'b1;
        fmt = IMM_I;
        bad = f3 == 3'b111;
      end
      OPC_STORE: begin
        d.op[OP_STORE] = 1'b1;
        fmt = IMM_S;
        bad = f3[2];
      end
      default: bad = 1'b1;
    endcase
    is_alu    = d.op[OP_ALU_IMM] | d.op[OP_ALU_IMM_W] | d.op[OP_ALU] | d.op[OP_ALU_W];
    // SUB only exists in register-register form; inst[30] selects SRA for both forms
    d.alu     = bad || !is_alu ? '0 : alu_onehot(f3, (d.op[OP_ALU] | d.op[OP_ALU_W]) & inst_i[30], inst_i[30]);
    d.br      = bad || !d.op[OP_BRANCH] ? '0 : br_onehot(f3);
    d.op      = bad ? '0 : d.op;
    d.rs1     = inst_i[19:15];
    d.rs2     = inst_i[24:20];
    d.rd      = inst_i[11:7];
    d.rd_wen  = wr & ~bad & (|inst_i[11:7]);
    d.illegal = bad;
  end
  idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst_i),
    .fmt_i  (fmt),
    .imm_o  (imm)
  );
  assign in_ready_o = ~valid | out_ready_i;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
      slot  <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (flush_i) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      slot  <= d;
      pc_q  <= pc_i;
      imm_q <= imm;
    end else if (out_ready_i) begin
      valid <= 1'b0;
    end
  end
  assign out_valid_o   = valid;
  assign pc_o          = pc_q;
  assign opcode_info_o = slot.op;
  assign alu_info_o    = slot.alu;
  assign branch_info_o = slot.br;
  assign imm_o         = imm_q;
  assign rs1_idx_o     = slot.rs1;
  assign rs2_idx_o     = slot.rs2;
  assign rd_idx_o      = slot.rd;
  assign rd_wen_o      = slot.rd_wen;
  assign illegal_o     = slot.illegal;
endmodule

// File: tb/tb_idu_decode_stage.sv
// tb_idu_decode_stage: directed vector table plus handshake/flush/reset sequences for idu_decode_stage
module tb_idu_decode_stage;
  import idu_decode_stage_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] inst_i;
  logic [63:0] pc_i, pc_o, imm_o;
  logic [OP_INFO_WIDTH-1:0]     opcode_info_o;
  logic [ALU_INFO_WIDTH-1:0]    alu_info_o;
  logic [BRANCH_INFO_WIDTH-1:0] branch_info_o;
  logic [4:0]  rs1_idx_o, rs2_idx_o, rd_idx_o;
  logic        rd_wen_o, illegal_o;
  int tests = 0;
  int fails = 0;
  always #5 clk_i = ~clk_i;
  idu_decode_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .opcode_info_o(opcode_info_o),
    .alu_info_o(alu_info_o), .branch_info_o(branch_info_o), .imm_o(imm_o),
    .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o), .rd_idx_o(rd_idx_o),
    .rd_wen_o(rd_wen_o), .illegal_o(illegal_o)
  );
  typedef struct {
    logic [31:0] inst;
    logic [OP_INFO_WIDTH-1:0]     op;
    logic [ALU_INFO_WIDTH-1:0]    alu;
    logic [BRANCH_INFO_WIDTH-1:0] br;
    logic [63:0] imm;
    logic        ci;
    logic [4:0]  rs1, rs2, rd;
    logic        wen, ill;
  } vec_t;
  vec_t v[15];
  function automatic logic [OP_INFO_WIDTH-1:0] opb(input int i);
    return OP_INFO_WIDTH'(1) << i;
  endfunction
  function automatic logic [ALU_INFO_WIDTH-1:0] alb(input int i);
    return ALU_INFO_WIDTH'(1) << i;
  endfunction
  function automatic logic [BRANCH_INFO_WIDTH-1:0] brb(input int i);
    return BRANCH_INFO_WIDTH'(1) << i;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    v[0]  = '{32'hFFF10093, opb(OP_ALU_IMM),   alb(ALU_ADD), '0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 31, 1, 1, 0};
    v[1]  = '{32'h402081B3, opb(OP_ALU),       alb(ALU_SUB), '0, 64'h0, 1, 1, 2, 3, 1, 0};
    v[2]  = '{32'hFE000EE3, opb(OP_BRANCH),    '0, brb(BRANCH_BEQ), 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 29, 0, 0};
    v[3]  = '{32'h800002B7, opb(OP_LUI),       '0, '0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 5, 1, 0};
    v[4]  = '{32'h0200109B, '0, '0, '0, 64'h0, 0, 0, 0, 1, 0, 1};
    v[5]  = '{32'h43F2D213, opb(OP_ALU_IMM),   alb(ALU_SRA), '0, 64'd63, 1, 5, 31, 4, 1, 0};
    v[6]  = '{32'hFE63AC23, opb(OP_STORE),     '0, '0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 7, 6, 24, 0, 0};
    v[7]  = '{32'h001000EF, opb(OP_JAL),       '0, '0, 64'h800, 1, 0, 1, 1, 1, 0};
    v[8]  = '{32'h0020803B, opb(OP_ALU_W),     alb(ALU_ADD), '0, 64'h0, 1, 1, 2, 0, 0, 0};
    v[9]  = '{32'h0020E463, opb(OP_BRANCH),    '0, brb(BRANCH_BLTU), 64'd8, 1, 1, 2, 8, 0, 0};
    v[10] = '{32'h0000007F, '0, '0, '0, 64'h0, 0, 0, 0, 0, 0, 1};
    v[11] = '{32'h000010E7, '0, '0, '0, 64'h0, 0, 0, 0, 1, 0, 1};
    v[12] = '{32'h01013283, opb(OP_LOAD),      '0, '0, 64'd16, 1, 2, 16, 5, 1, 0};
    v[13] = '{32'h00001397, opb(OP_AUIPC),     '0, '0, 64'h1000, 1, 0, 0, 7, 1, 0};
    v[14] = '{32'h00002063, '0, '0, '0, 64'h0, 0, 0, 0, 0, 0, 1};
    rst_n_i = 1'b0;
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    inst_i = 32'h0;
    pc_i = 64'h0;
    repeat (2) step();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_op", opcode_info_o, 0);
    chk("rst_rd", rd_idx_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    rst_n_i = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      inst_i = v[i].inst;
      pc_i = 64'h8000_0000 + 64'(i * 4);
      in_valid_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      chk($sformatf("v%0d_valid", i), out_valid_o, 1);
      chk($sformatf("v%0d_pc", i), pc_o, 64'h8000_0000 + 64'(i * 4));
      chk($sformatf("v%0d_op", i), opcode_info_o, v[i].op);
      chk($sformatf("v%0d_alu", i), alu_info_o, v[i].alu);
      chk($sformatf("v%0d_br", i), branch_info_o, v[i].br);
      if (v[i].ci) chk($sformatf("v%0d_imm", i), imm_o, v[i].imm);
      chk($sformatf("v%0d_rs1", i), rs1_idx_o, v[i].rs1);
      chk($sformatf("v%0d_rs2", i), rs2_idx_o, v[i].rs2);
      chk($sformatf("v%0d_rd", i), rd_idx_o, v[i].rd);
      chk($sformatf("v%0d_wen", i), rd_wen_o, v[i].wen);
      chk($sformatf("v%0d_ill", i), illegal_o, v[i].ill);
    end
    in_valid_i = 1'b0;
    step();
    chk("drain_valid", out_valid_o, 0);
    inst_i = v[0].inst;
    pc_i = 64'hA0;
    in_valid_i = 1'b1;
    step();
    inst_i = v[1].inst;
    pc_i = 64'hB0;
    out_ready_i = 1'b0;
    #1;
    chk("bp_in_ready", in_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("bp%0d_valid", c), out_valid_o, 1);
      chk($sformatf("bp%0d_pc", c), pc_o, 64'hA0);
      chk($sformatf("bp%0d_alu", c), alu_info_o, alb(ALU_ADD));
      chk($sformatf("bp%0d_in_ready", c), in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    step();
    chk("bp_next_valid", out_valid_o, 1);
    chk("bp_next_pc", pc_o, 64'hB0);
    chk("bp_next_alu", alu_info_o, alb(ALU_SUB));
    in_valid_i = 1'b0;
    step();
    chk("bp_end_valid", out_valid_o, 0);
    inst_i = v[0].inst;
    pc_i = 64'hC0;
    in_valid_i = 1'b1;
    step();
    chk("fl_held_valid", out_valid_o, 1);
    chk("fl_held_pc", pc_o, 64'hC0);
    inst_i = v[1].inst;
    pc_i = 64'hD0;
    flush_i = 1'b1;
    out_ready_i = 1'b0;
    step();
    chk("fl_valid", out_valid_o, 0);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    chk("fl_after_valid", out_valid_o, 0);
    inst_i = v[3].inst;
    pc_i = 64'hE0;
    in_valid_i = 1'b1;
    step();
    chk("mr_valid", out_valid_o, 1);
    chk("mr_pc", pc_o, 64'hE0);
    rst_n_i = 1'b0;
    #1;
    chk("mr_rst_valid", out_valid_o, 0);
    chk("mr_rst_pc", pc_o, 0);
    chk("mr_rst_imm", imm_o, 0);
    chk("mr_rst_op", opcode_info_o, 0);
    chk("mr_rst_rd", rd_idx_o, 0);
    chk("mr_rst_wen", rd_wen_o, 0);
    step();
    chk("mr_hold_valid", out_valid_o, 0);
    rst_n_i = 1'b1;
    in_valid_i = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
